// File: rtl/cache_arb_pkg.sv
// Shared types for the cache/memory arbiter: FSM state encoding and
// read-owner identifiers used to steer returning read beats.
package cache_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    GNT_IC_RD = 2'b01,
    GNT_DC_RD = 2'b10,
    GNT_DC_WR = 2'b11
  } t_arb_state;

  typedef enum logic {
    OWNER_IC = 1'b0,
    OWNER_DC = 1'b1
  } t_owner;

endpackage

// File: rtl/cache_mem_arbiter.sv
// Single-outstanding arbiter sharing the memory burst channel between the I-cache
// and D-cache FSMs. Define CACHE_ARB_ROUND_ROBIN_EN for round-robin between caches.
module cache_mem_arbiter
  import cache_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  i_ic_start_read,
  input  logic [ADDR_WIDTH-1:0] i_ic_addr,
  input  logic                  i_dc_start_read,
  input  logic                  i_dc_start_write,
  input  logic [ADDR_WIDTH-1:0] i_dc_addr,
  input  logic                  i_r_last,
  input  logic                  i_b_resp,
  output logic                  o_start_read,
  output logic                  o_start_write,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_ic_r_last,
  output logic                  o_dc_r_last,
  output logic                  o_dc_b_resp,
  output logic                  o_rd_owner
);

  t_arb_state            state;
  t_arb_state            next_state;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  dc_req;
  logic                  dc_wins;

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  t_owner last_owner;
`endif

  assign dc_req = i_dc_start_write | i_dc_start_read;

  // On a tie the D-cache goes first unless round-robin says it had the last turn.
`ifdef CACHE_ARB_ROUND_ROBIN_EN
  assign dc_wins = dc_req & ~(i_ic_start_read & (last_owner == OWNER_DC));
`else
  assign dc_wins = dc_req;
`endif

  always_comb begin
    next_state = state;
    next_addr  = o_addr;
    case (state)
      IDLE: begin
        if (dc_wins) begin
          next_state = i_dc_start_write ? GNT_DC_WR : GNT_DC_RD;
          next_addr  = i_dc_addr;
        end else if (i_ic_start_read) begin
          next_state = GNT_IC_RD;
          next_addr  = i_ic_addr;
        end
      end
      GNT_IC_RD: if (i_r_last) next_state = IDLE;
      GNT_DC_RD: if (i_r_last) next_state = IDLE;
      GNT_DC_WR: if (i_b_resp) next_state = IDLE;
      default:   next_state = IDLE;
    endcase
  end

  // Grant outputs are registered alongside the state so they track it exactly.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      state         <= IDLE;
      o_addr        <= '0;
      o_start_read  <= 1'b0;
      o_start_write <= 1'b0;
      o_rd_owner    <= 1'b0;
    end else begin
      state         <= next_state;
      o_addr        <= next_addr;
      o_start_read  <= (next_state == GNT_IC_RD) || (next_state == GNT_DC_RD);
      o_start_write <= (next_state == GNT_DC_WR);
      o_rd_owner    <= (next_state == GNT_DC_RD);
    end
  end

`ifdef CACHE_ARB_ROUND_ROBIN_EN
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      last_owner <= OWNER_IC;
    end else if (state == IDLE && next_state != IDLE) begin
      last_owner <= (next_state == GNT_IC_RD) ? OWNER_IC : OWNER_DC;
    end
  end
`endif

  // Completions reach only the owner; anything arriving in the wrong state is dropped.
  assign o_ic_r_last = (state == GNT_IC_RD) & i_r_last;
  assign o_dc_r_last = (state == GNT_DC_RD) & i_r_last;
  assign o_dc_b_resp = (state == GNT_DC_WR) & i_b_resp;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter; expectations follow
// CACHE_ARB_ROUND_ROBIN_EN when the bench is built with that macro.
module tb_cache_mem_arbiter;

  localparam int AW = 64;

  logic          clk = 1'b0;
  logic          arstn;
  logic          i_ic_start_read;
  logic [AW-1:0] i_ic_addr;
  logic          i_dc_start_read;
  logic          i_dc_start_write;
  logic [AW-1:0] i_dc_addr;
  logic          i_r_last;
  logic          i_b_resp;
  logic          o_start_read;
  logic          o_start_write;
  logic [AW-1:0] o_addr;
  logic          o_ic_r_last;
  logic          o_dc_r_last;
  logic          o_dc_b_resp;
  logic          o_rd_owner;

  int checks   = 0;
  int failures = 0;

  cache_mem_arbiter #(.ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .arstn           (arstn),
    .i_ic_start_read (i_ic_start_read),
    .i_ic_addr       (i_ic_addr),
    .i_dc_start_read (i_dc_start_read),
    .i_dc_start_write(i_dc_start_write),
    .i_dc_addr       (i_dc_addr),
    .i_r_last        (i_r_last),
    .i_b_resp        (i_b_resp),
    .o_start_read    (o_start_read),
    .o_start_write   (o_start_write),
    .o_addr          (o_addr),
    .o_ic_r_last     (o_ic_r_last),
    .o_dc_r_last     (o_dc_r_last),
    .o_dc_b_resp     (o_dc_b_resp),
    .o_rd_owner      (o_rd_owner)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    arstn = 1'b0;
    i_ic_start_read = 0; i_ic_addr = '0;
    i_dc_start_read = 0; i_dc_start_write = 0; i_dc_addr = '0;
    i_r_last = 0; i_b_resp = 0;
    tick(); tick();
    checks++;
    if ({o_start_read, o_start_write, o_rd_owner, o_ic_r_last, o_dc_r_last, o_dc_b_resp} !== 6'b0) begin
      failures++;
      $display("[TB] FAIL reset_ctrl got=%b want=000000",
               {o_start_read, o_start_write, o_rd_owner, o_ic_r_last, o_dc_r_last, o_dc_b_resp});
    end
    checks++;
    if (o_addr !== 64'h0) begin
      failures++; $display("[TB] FAIL reset_addr got=%h want=0", o_addr);
    end
    arstn = 1'b1;
    tick();
    checks++;
    if (o_start_read !== 1'b0 || o_start_write !== 1'b0) begin
      failures++; $display("[TB] FAIL idle_no_req got=%b%b want=00", o_start_read, o_start_write);
    end
  endtask

  task automatic test_ic_fill();
    i_ic_start_read = 1; i_ic_addr = 64'h1000;
    #1;
    checks++;
    if (o_start_read !== 1'b0) begin
      failures++; $display("[TB] FAIL ic_latency got=%b want=0", o_start_read);
    end
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b0 || o_addr !== 64'h1000) begin
      failures++;
      $display("[TB] FAIL ic_grant got rd=%b own=%b addr=%h want rd=1 own=0 addr=1000",
               o_start_read, o_rd_owner, o_addr);
    end
    i_r_last = 1; #1;
    checks++;
    if (o_ic_r_last !== 1'b1 || o_dc_r_last !== 1'b0 || o_dc_b_resp !== 1'b0) begin
      failures++;
      $display("[TB] FAIL ic_complete got ic=%b dc=%b b=%b want ic=1 dc=0 b=0",
               o_ic_r_last, o_dc_r_last, o_dc_b_resp);
    end
    tick();
    i_ic_start_read = 0; i_r_last = 0; #1;
    checks++;
    if (o_start_read !== 1'b0 || o_ic_r_last !== 1'b0) begin
      failures++; $display("[TB] FAIL ic_release got rd=%b ic=%b want 0 0", o_start_read, o_ic_r_last);
    end
  endtask

  // Tie with last_owner = IC (after the IC fill): D-cache first in both builds.
  task automatic test_simultaneous();
    i_ic_start_read = 1; i_ic_addr = 64'h1100;
    i_dc_start_read = 1; i_dc_addr = 64'h5500;
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b1 || o_addr !== 64'h5500) begin
      failures++;
      $display("[TB] FAIL pair_first got rd=%b own=%b addr=%h want 1 1 5500", o_start_read, o_rd_owner, o_addr);
    end
    i_r_last = 1; #1;
    checks++;
    if (o_dc_r_last !== 1'b1 || o_ic_r_last !== 1'b0) begin
      failures++; $display("[TB] FAIL pair_dc_done got dc=%b ic=%b want 1 0", o_dc_r_last, o_ic_r_last);
    end
    tick();
    i_dc_start_read = 0; i_r_last = 0; #1;
    checks++;
    if (o_start_read !== 1'b0) begin
      failures++; $display("[TB] FAIL pair_idle_gap got=%b want=0", o_start_read);
    end
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b0 || o_addr !== 64'h1100) begin
      failures++;
      $display("[TB] FAIL pair_second got rd=%b own=%b addr=%h want 1 0 1100", o_start_read, o_rd_owner, o_addr);
    end
    i_r_last = 1; tick();
    i_ic_start_read = 0; i_r_last = 0;
  endtask

  // Write and read both raised: write first, then the fill after one idle cycle.
  task automatic test_wb_then_fill();
    i_dc_start_write = 1; i_dc_start_read = 1; i_dc_addr = 64'h2040;
    tick();
    checks++;
    if (o_start_write !== 1'b1 || o_start_read !== 1'b0 || o_addr !== 64'h2040) begin
      failures++;
      $display("[TB] FAIL wb_grant got wr=%b rd=%b addr=%h want 1 0 2040", o_start_write, o_start_read, o_addr);
    end
    i_b_resp = 1; #1;
    checks++;
    if (o_dc_b_resp !== 1'b1 || o_dc_r_last !== 1'b0) begin
      failures++; $display("[TB] FAIL wb_resp got b=%b r=%b want 1 0", o_dc_b_resp, o_dc_r_last);
    end
    tick();
    i_dc_start_write = 0; i_b_resp = 0; #1;
    checks++;
    if (o_start_write !== 1'b0 || o_start_read !== 1'b0) begin
      failures++; $display("[TB] FAIL wb_idle_gap got wr=%b rd=%b want 0 0", o_start_write, o_start_read);
    end
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b1 || o_addr !== 64'h2040) begin
      failures++;
      $display("[TB] FAIL fill_after_wb got rd=%b own=%b addr=%h want 1 1 2040", o_start_read, o_rd_owner, o_addr);
    end
    i_r_last = 1; tick();
    i_dc_start_read = 0; i_r_last = 0;
  endtask

  // Tie with last_owner = DC: round-robin hands it to the I-cache first.
  task automatic test_round_robin();
    logic exp_first_owner;
`ifdef CACHE_ARB_ROUND_ROBIN_EN
    exp_first_owner = 1'b0;
`else
    exp_first_owner = 1'b1;
`endif
    i_ic_start_read = 1; i_ic_addr = 64'h1200;
    i_dc_start_read = 1; i_dc_addr = 64'h6600;
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== exp_first_owner) begin
      failures++;
      $display("[TB] FAIL rr_first got rd=%b own=%b want 1 %b", o_start_read, o_rd_owner, exp_first_owner);
    end
    i_r_last = 1; tick();
    if (exp_first_owner) i_dc_start_read = 0; else i_ic_start_read = 0;
    i_r_last = 0;
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== ~exp_first_owner) begin
      failures++;
      $display("[TB] FAIL rr_second got rd=%b own=%b want 1 %b", o_start_read, o_rd_owner, ~exp_first_owner);
    end
    i_r_last = 1; tick();
    i_ic_start_read = 0; i_dc_start_read = 0; i_r_last = 0;
  endtask

  task automatic test_spurious();
    i_r_last = 1; i_b_resp = 1; #1;
    checks++;
    if ({o_ic_r_last, o_dc_r_last, o_dc_b_resp} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL spur_idle got=%b want=000", {o_ic_r_last, o_dc_r_last, o_dc_b_resp});
    end
    tick();
    checks++;
    if (o_start_read !== 1'b0 || o_start_write !== 1'b0) begin
      failures++; $display("[TB] FAIL spur_idle_state got rd=%b wr=%b want 0 0", o_start_read, o_start_write);
    end
    i_r_last = 0; i_b_resp = 0;
    i_dc_start_write = 1; i_dc_addr = 64'h7000;
    tick();
    i_r_last = 1; #1;
    checks++;
    if ({o_ic_r_last, o_dc_r_last, o_dc_b_resp} !== 3'b000) begin
      failures++;
      $display("[TB] FAIL spur_wr got=%b want=000", {o_ic_r_last, o_dc_r_last, o_dc_b_resp});
    end
    tick();
    i_r_last = 0; #1;
    checks++;
    if (o_start_write !== 1'b1) begin
      failures++; $display("[TB] FAIL spur_wr_hold got=%b want=1", o_start_write);
    end
    i_b_resp = 1; tick();
    i_dc_start_write = 0; i_b_resp = 0;
    tick();
  endtask

  task automatic test_addr_hold();
    i_dc_start_read = 1; i_dc_addr = 64'h3000;
    tick();
    i_dc_addr = 64'h4000;
    tick(); tick();
    checks++;
    if (o_addr !== 64'h3000 || o_start_read !== 1'b1) begin
      failures++; $display("[TB] FAIL addr_hold got addr=%h rd=%b want 3000 1", o_addr, o_start_read);
    end
    i_r_last = 1; tick();
    i_dc_start_read = 0; i_r_last = 0;
    tick();
  endtask

  task automatic test_reset_mid();
    i_dc_start_read = 1; i_dc_addr = 64'h8800;
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b1) begin
      failures++; $display("[TB] FAIL rst_mid_pre got rd=%b own=%b want 1 1", o_start_read, o_rd_owner);
    end
    arstn = 0; i_r_last = 1; #1;
    checks++;
    if ({o_start_read, o_start_write, o_rd_owner, o_ic_r_last, o_dc_r_last, o_dc_b_resp} !== 6'b0 ||
        o_addr !== 64'h0) begin
      failures++;
      $display("[TB] FAIL rst_mid_clear got ctrl=%b addr=%h want 000000 0",
               {o_start_read, o_start_write, o_rd_owner, o_ic_r_last, o_dc_r_last, o_dc_b_resp}, o_addr);
    end
    i_r_last = 0;
    tick();
    arstn = 1; #1;
    checks++;
    if (o_start_read !== 1'b0) begin
      failures++; $display("[TB] FAIL rst_release got=%b want=0", o_start_read);
    end
    tick();
    checks++;
    if (o_start_read !== 1'b1 || o_rd_owner !== 1'b1 || o_addr !== 64'h8800) begin
      failures++;
      $display("[TB] FAIL rst_regrant got rd=%b own=%b addr=%h want 1 1 8800", o_start_read, o_rd_owner, o_addr);
    end
    i_r_last = 1; tick();
    i_dc_start_read = 0; i_r_last = 0;
    tick();
  endtask

  initial begin
    test_reset();
    test_ic_fill();
    test_simultaneous();
    test_wb_then_fill();
    test_round_robin();
    test_spurious();
    test_addr_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares the single external memory read/write channel between the instruction cache FSM and the data cache FSM.
- Grants exactly one outstanding transaction at a time: an I-cache line fill, a D-cache line fill or a D-cache write-back.
- Holds the grant until memory signals completion, then routes the completion pulse back only to the owning requester.
- Sits between both cache FSMs and the memory interface master that drives burst reads and writes.

Parameters:
- ADDR_WIDTH, 64, width of the line address presented to memory.

Ports:
- clk  in  1  clock
- arstn  in  1  asynchronous active-low reset
- i_ic_start_read  in  1  I-cache fill request; held high until its completion is returned
- i_ic_addr  in  ADDR_WIDTH  I-cache fill line address
- i_dc_start_read  in  1  D-cache fill request; held until completion
- i_dc_start_write  in  1  D-cache write-back request; held until completion
- i_dc_addr  in  ADDR_WIDTH  D-cache line address for the fill or write-back
- i_r_last  in  1  memory: last beat of the read burst
- i_b_resp  in  1  memory: write response
- o_start_read  out  1  to memory: perform burst read
- o_start_write  out  1  to memory: perform burst write
- o_addr  out  ADDR_WIDTH  to memory: latched address of the granted transaction
- o_ic_r_last  out  1  completion routed to the I-cache
- o_dc_r_last  out  1  read completion routed to the D-cache
- o_dc_b_resp  out  1  write completion routed to the D-cache
- o_rd_owner  out  1  0 = I-cache, 1 = D-cache; steers read data beats; valid while o_start_read is high

Behaviour:
- Reset is asynchronous, active-low, with clock clk.
- Reset values: state IDLE; o_start_read, o_start_write, o_rd_owner, o_addr, and all completion outputs are 0.
- The state machine has four states: IDLE, GNT_IC_RD, GNT_DC_RD, GNT_DC_WR.
- IDLE, arbitration order: dc_start_write, then dc_start_read, then ic_start_read (fixed priority; D-cache ahead of I-cache).
  - The winner's state is entered on the next edge.
  - The winner's address is registered into o_addr on that same edge.
  - With no request, the block stays in IDLE.
- If dc_start_write and dc_start_read are both high, the write wins.
- Grant outputs are Moore, decoded from the registered state:
  - GNT_IC_RD: o_start_read = 1, o_rd_owner = 0.
  - GNT_DC_RD: o_start_read = 1, o_rd_owner = 1.
  - GNT_DC_WR: o_start_write = 1.
- Grant latency: one clock from request seen in IDLE to o_start_* high.
- Completion routing is combinational in the same cycle:
  - GNT_IC_RD with i_r_last: o_ic_r_last = 1.
  - GNT_DC_RD with i_r_last: o_dc_r_last = 1.
  - GNT_DC_WR with i_b_resp: o_dc_b_resp = 1.
- Completion transitions the state to IDLE on the next edge, so there is one idle cycle between grants.
- The requester drops its start signal on the edge where it receives completion. IDLE therefore never re-grants a finished request.
- Spurious completions are dropped, not forwarded: i_r_last in IDLE or GNT_DC_WR, and i_b_resp in IDLE or a read grant.
- Requests that deassert before completion are not permitted. The grant holds until completion regardless.
- o_addr is stable for the whole grant. Requester address changes mid-grant are ignored.
- A D-cache write-back followed by its fill re-arbitrates. The I-cache may win in between only under the optional feature below.
- arstn asserted mid-transaction returns to IDLE immediately and clears all outputs. No completion pulse is generated.

Optional Feature:
- Macro: CACHE_ARB_ROUND_ROBIN_EN.
- Defined:
  - A 1-bit last_owner register (reset 0 = I-cache) is updated on each grant.
  - In IDLE, when both caches request, the cache that was not last_owner wins.
  - D-cache write-over-read priority within the D-cache still applies.
- Undefined: fixed priority as above; no last_owner register.

Decomposition:
- Shared package cache_arb_pkg holds:
  - t_arb_state enum (IDLE = 2'b00, GNT_IC_RD = 2'b01, GNT_DC_RD = 2'b10, GNT_DC_WR = 2'b11);
  - t_owner enum (OWNER_IC = 1'b0, OWNER_DC = 1'b1).
- No sub-module; the selection logic is a single always_comb block inside cache_mem_arbiter.

Test Plan:
- Reset, then only i_ic_start_read = 1 with i_ic_addr = 0x1000:
  - next cycle, o_start_read = 1, o_rd_owner = 0, o_addr = 0x1000;
  - i_r_last pulse gives o_ic_r_last = 1 that cycle and o_dc_r_last = 0;
  - following cycle, o_start_read = 0.
- i_ic_start_read and i_dc_start_read rise in the same cycle:
  - D-cache is granted first (o_rd_owner = 1);
  - after i_r_last plus one idle cycle, the I-cache is granted;
  - with CACHE_ARB_ROUND_ROBIN_EN, a second simultaneous pair is granted to the I-cache first.
- D-cache write-back (address 0x2040), i_b_resp, then the D-cache read from the same address:
  - o_start_write for the grant;
  - o_dc_b_resp pulse;
  - one idle cycle;
  - o_start_read with o_addr = 0x2040.
- i_r_last pulsed during GNT_DC_WR and during IDLE: no completion output asserts and the state is unchanged.
- i_dc_addr changes from 0x3000 to 0x4000 mid-grant: o_addr holds 0x3000 until completion.
- arstn asserted during GNT_DC_RD: all outputs are 0 immediately; after release, with the request still high, regrant occurs one cycle later.
